// File: rtl/sdram_port_arbiter_if.sv
// Requester-side and controller-side signal bundle for sdram_port_arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface sdram_port_arbiter_if #(
   parameter int NREQ       = 4,
   parameter int ADDR_DEPTH = 25,
   parameter int DATA_W     = 8
);
   logic [NREQ-1:0]            req_valid;
   logic [NREQ-1:0]            req_we;
   logic [NREQ*ADDR_DEPTH-1:0] req_addr;
   logic [NREQ*DATA_W-1:0]     req_wdata;
   logic [NREQ-1:0]            req_ready;
   logic [NREQ-1:0]            rsp_valid;
   logic [DATA_W-1:0]          rsp_data;
   logic [ADDR_DEPTH-1:0]      ctl_addr;
   logic [DATA_W-1:0]          ctl_data_wr;
   logic                       ctl_wr;
   logic                       ctl_rd;
   logic                       ctl_rdy;
   logic                       ctl_val;
   logic [DATA_W-1:0]          ctl_data_rd;
   logic                       tag_err;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, ctl_rdy, ctl_val, ctl_data_rd,
      output req_ready, rsp_valid, rsp_data, ctl_addr, ctl_data_wr, ctl_wr, ctl_rd, tag_err
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, ctl_rdy, ctl_val, ctl_data_rd,
      input  req_ready, rsp_valid, rsp_data, ctl_addr, ctl_data_wr, ctl_wr, ctl_rd, tag_err
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port, with in-order read tag routing.
// Optional macro SDRAM_ARB_PRIO0_EN: requester 0 gets fixed priority, the rest rotate among themselves.
//
// state | meaning
// IDLE  | no command driven; arbitrate among eligible requesters
// HOLD  | registered grant driven on ctl_*, waiting for ctl_rdy
module sdram_port_arbiter #(
   parameter int NREQ       = 4,
   parameter int ADDR_DEPTH = 25,
   parameter int DATA_W     = 8,
   parameter int TAG_DEPTH  = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   sdram_port_arbiter_if.slave bus
);
   localparam int GW = $clog2(NREQ);
   localparam int PW = $clog2(TAG_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   rr_q, rr_d;
   logic [GW-1:0]   tag_q [TAG_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            tag_err_q;

   logic            tag_full, tag_empty;
   logic            push, pop;
   logic [NREQ-1:0] eligible;
   logic            found;
   logic [GW-1:0]   pick;
   logic [GW-1:0]   cand;
   logic [GW-1:0]   rr_next;
   logic            grant_we;

   assign tag_full  = (count_q == CW'(TAG_DEPTH));
   assign tag_empty = (count_q == '0);
   assign pop       = bus.ctl_val & ~tag_empty;

   // A read is held back only when it could not get a tag slot.
   assign eligible  = bus.req_valid & ~(~bus.req_we & {NREQ{tag_full}});

`ifdef SDRAM_ARB_PRIO0_EN
   int rr_base;

   always_comb begin
      found   = 1'b0;
      pick    = '0;
      cand    = '0;
      rr_base = (rr_q == '0) ? 0 : int'(rr_q) - 1;
      if (eligible[0]) begin
         found = 1'b1;
      end else begin
         for (int k = 0; k < NREQ - 1; k++) begin
            cand = GW'(1 + ((rr_base + k) % (NREQ - 1)));
            if (!found && eligible[cand]) begin
               found = 1'b1;
               pick  = cand;
            end
         end
      end
   end

   // Serving requester 0 leaves the rotation of the others untouched.
   always_comb begin
      if (grant_q == '0)
         rr_next = rr_q;
      else if (grant_q == GW'(NREQ - 1))
         rr_next = GW'(1);
      else
         rr_next = grant_q + GW'(1);
   end
`else
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = GW'((int'(rr_q) + k) % NREQ);
         if (!found && eligible[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      if (grant_q == GW'(NREQ - 1))
         rr_next = '0;
      else
         rr_next = grant_q + GW'(1);
   end
`endif

   always_comb begin
      state_d         = state_q;
      grant_d         = grant_q;
      rr_d            = rr_q;
      push            = 1'b0;
      grant_we        = bus.req_we[grant_q];
      bus.req_ready   = '0;
      bus.ctl_wr      = 1'b0;
      bus.ctl_rd      = 1'b0;
      bus.ctl_addr    = '0;
      bus.ctl_data_wr = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = pick;
               state_d = HOLD;
            end
         end
         HOLD: begin
            bus.ctl_wr      = grant_we;
            bus.ctl_rd      = ~grant_we;
            bus.ctl_addr    = bus.req_addr[int'(grant_q)*ADDR_DEPTH +: ADDR_DEPTH];
            bus.ctl_data_wr = bus.req_wdata[int'(grant_q)*DATA_W +: DATA_W];
            if (bus.ctl_rdy) begin
               bus.req_ready[grant_q] = 1'b1;
               rr_d    = rr_next;
               push    = ~grant_we;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read data goes to the oldest outstanding tag; nothing is routed when no tag exists.
   always_comb begin
      bus.rsp_valid = '0;
      if (pop)
         bus.rsp_valid[tag_q[rd_ptr_q]] = 1'b1;
      bus.rsp_data = bus.ctl_val ? bus.ctl_data_rd : '0;
   end

   assign bus.tag_err = tag_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         rr_q      <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         tag_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         if (push)
            wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (bus.ctl_val && tag_empty)
            tag_err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         tag_q[wr_ptr_q] <= grant_q;
   end

   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.req_ready));
   a_rsp_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.rsp_valid));
   a_cmd_excl:     assert property (@(posedge clk) disable iff (!rst_n) !(bus.ctl_wr && bus.ctl_rd));
   a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && tag_full && !pop));
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized scoreboard bench for sdram_port_arbiter against a queue-based reference model.
module tb_sdram_port_arbiter;
   localparam int NREQ = 4;
   localparam int AW   = 25;
   localparam int DW   = 8;
   localparam int TD   = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sdram_port_arbiter_if #(.NREQ(NREQ), .ADDR_DEPTH(AW), .DATA_W(DW)) bus ();

   sdram_port_arbiter #(.NREQ(NREQ), .ADDR_DEPTH(AW), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   typedef struct {
      int   cyc;
      int   r;
      cmd_t c;
   } grant_t;

   typedef struct {
      int cyc;
      int r;
   } acc_t;

   typedef struct {
      int            cyc;
      int            r;
      logic [DW-1:0] d;
   } rsp_t;

   grant_t exp_grant[$];
   acc_t   exp_acc[$];
   rsp_t   exp_rsp[$];
   rsp_t   m_out[$];

   bit   pend_v [NREQ];
   cmd_t pend   [NREQ];

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;

   int m_busy = 0;
   int m_g    = 0;
   int m_rr   = 0;
   bit exp_tag_err = 1'b0;

   int gen_en  = 1;
   int p_new   = 100;
   int p_write = 100;
   int p_rdy   = 100;
   int p_val   = 50;
   bit force_val = 1'b0;
   bit mon_en    = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit any_pend();
      for (int i = 0; i < NREQ; i++)
         if (pend_v[i]) return 1'b1;
      return 1'b0;
   endfunction

   // Arbitration rule: first eligible at/after the rotation point; reads need a free tag.
   function automatic int model_pick(bit full);
      bit elig [NREQ];
      int i;
      for (int j = 0; j < NREQ; j++)
         elig[j] = pend_v[j] && !(!pend[j].we && full);
`ifdef SDRAM_ARB_PRIO0_EN
      if (elig[0]) return 0;
      for (int k = 0; k < NREQ - 1; k++) begin
         i = 1 + ((m_rr - 1 + k) % (NREQ - 1));
         if (elig[i]) return i;
      end
`else
      for (int k = 0; k < NREQ; k++) begin
         i = (m_rr + k) % NREQ;
         if (elig[i]) return i;
      end
`endif
      return -1;
   endfunction

   function automatic int model_next_rr(int g);
`ifdef SDRAM_ARB_PRIO0_EN
      return (g == 0) ? m_rr : (g % (NREQ - 1)) + 1;
`else
      return (g + 1) % NREQ;
`endif
   endfunction

   task automatic model_cycle();
      bit     full0;
      int     g;
      rsp_t   r;
      acc_t   a;
      grant_t gr;
      full0 = (m_out.size() == TD);
      if (bus.ctl_val) begin
         if (m_out.size() > 0) begin
            r     = m_out.pop_front();
            r.cyc = cyc;
            exp_rsp.push_back(r);
         end else begin
            exp_tag_err = 1'b1;
         end
      end
      if (m_busy != 0) begin
         if (bus.ctl_rdy) begin
            a.cyc = cyc;
            a.r   = m_g;
            exp_acc.push_back(a);
            if (!pend[m_g].we) begin
               r.cyc = 0;
               r.r   = m_g;
               r.d   = DW'($urandom);
               m_out.push_back(r);
            end
            m_rr       = model_next_rr(m_g);
            pend_v[m_g] = 1'b0;
            m_busy     = 0;
         end
      end else begin
         g = model_pick(full0);
         if (g >= 0) begin
            gr.cyc = cyc + 1;
            gr.r   = g;
            gr.c   = pend[g];
            exp_grant.push_back(gr);
            m_busy = 1;
            m_g    = g;
         end
      end
   endtask

   task automatic step();
      bit vbit;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
         if (!pend_v[i] && gen_en != 0 && $urandom_range(99) < p_new) begin
            pend_v[i]      = 1'b1;
            pend[i].we     = ($urandom_range(99) < p_write);
            pend[i].addr   = AW'($urandom);
            pend[i].wdata  = DW'($urandom);
         end
         bus.req_valid[i]              = pend_v[i];
         bus.req_we[i]                 = pend[i].we;
         bus.req_addr[i*AW +: AW]      = pend[i].addr;
         bus.req_wdata[i*DW +: DW]     = pend[i].wdata;
      end
      bus.ctl_rdy = ($urandom_range(99) < p_rdy);
      vbit = 1'b0;
      if (m_out.size() > 0 && $urandom_range(99) < p_val)
         vbit = 1'b1;
      else if (force_val && m_out.size() == 0)
         vbit = 1'b1;
      bus.ctl_val     = vbit;
      bus.ctl_data_rd = (vbit && m_out.size() > 0) ? m_out[0].d : DW'($urandom);
      model_cycle();
   endtask

   task automatic drain(input string name);
      int t;
      gen_en = 0;
      p_rdy  = 100;
      p_val  = 100;
      t      = 0;
      while ((m_busy != 0 || m_out.size() > 0 || any_pend()) && t < 300) begin
         step();
         t++;
      end
      chk(name, (t < 300), 1'b1);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a command, accept or response.
   bit     prev_cmd = 1'b0;
   bit     prev_acc = 1'b0;
   grant_t cur;
   acc_t   ea;
   rsp_t   er;

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.ctl_wr || bus.ctl_rd) begin
            if (!(prev_cmd && !prev_acc)) begin
               if (exp_grant.size() == 0) begin
                  chk("grant_unexpected", 1'b1, 1'b0);
               end else begin
                  cur = exp_grant.pop_front();
                  chk("grant_cycle", cyc, cur.cyc);
               end
            end
            chk("ctl_wr", bus.ctl_wr, cur.c.we);
            chk("ctl_rd", bus.ctl_rd, !cur.c.we);
            chk("ctl_addr", bus.ctl_addr, cur.c.addr);
            if (cur.c.we)
               chk("ctl_data_wr", bus.ctl_data_wr, cur.c.wdata);
         end
         if (bus.req_ready != '0) begin
            if (exp_acc.size() == 0) begin
               chk("ready_unexpected", bus.req_ready, 0);
            end else begin
               ea = exp_acc.pop_front();
               chk("req_ready", bus.req_ready, NREQ'(1) << ea.r);
               chk("ready_cycle", cyc, ea.cyc);
            end
         end
         if (bus.rsp_valid != '0) begin
            if (exp_rsp.size() == 0) begin
               chk("rsp_unexpected", bus.rsp_valid, 0);
            end else begin
               er = exp_rsp.pop_front();
               chk("rsp_valid", bus.rsp_valid, NREQ'(1) << er.r);
               chk("rsp_data", bus.rsp_data, er.d);
               chk("rsp_cycle", cyc, er.cyc);
            end
         end
         prev_cmd = bus.ctl_wr || bus.ctl_rd;
         prev_acc = (bus.req_ready != '0);
      end
   end

   initial begin
`ifdef SDRAM_ARB_PRIO0_EN
      m_rr = 1;
`endif
      for (int i = 0; i < NREQ; i++) begin
         pend_v[i] = 1'b0;
         pend[i]   = '0;
      end
      bus.req_valid   = '1;
      bus.req_we      = '0;
      bus.req_addr    = '0;
      bus.req_wdata   = '0;
      bus.ctl_rdy     = 1'b0;
      bus.ctl_val     = 1'b0;
      bus.ctl_data_rd = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_ctl_wr", bus.ctl_wr, 0);
      chk("rst_ctl_rd", bus.ctl_rd, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_tag_err", bus.tag_err, 0);
      chk("rst_ctl_addr", bus.ctl_addr, 0);
      @(negedge clk);
      bus.req_valid = '0;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // All requesters writing with an always-ready controller: rotation order.
      gen_en = 1; p_new = 100; p_write = 100; p_rdy = 100; p_val = 50;
      repeat (40) step();

      // Slow controller: commands must stay parked until ctl_rdy.
      p_new = 70; p_write = 50; p_rdy = 15; p_val = 30;
      repeat (300) step();

      // Read-heavy with slow returns: tag FIFO fills, writes keep flowing.
      p_new = 60; p_write = 10; p_rdy = 70; p_val = 5;
      repeat (400) step();

      for (int seg = 0; seg < 20; seg++) begin
         p_new   = $urandom_range(100, 10);
         p_write = $urandom_range(100, 0);
         p_rdy   = $urandom_range(100, 10);
         p_val   = $urandom_range(100, 5);
         repeat (100) step();
      end
      drain("drain1_timeout");

      step();
      chk("tag_err_clear", bus.tag_err, exp_tag_err);
      force_val = 1'b1;
      step();
      force_val = 1'b0;
      step();
      chk("tag_err_set", bus.tag_err, exp_tag_err);
      chk("tag_err_expect", exp_tag_err, 1'b1);

      gen_en = 1; p_new = 50; p_write = 40; p_rdy = 60; p_val = 40;
      repeat (200) step();
      drain("drain2_timeout");
      chk("tag_err_sticky", bus.tag_err, 1'b1);

      repeat (3) step();
      @(negedge clk);
      #1;
      chk("left_grants", exp_grant.size(), 0);
      chk("left_accepts", exp_acc.size(), 0);
      chk("left_rsps", exp_rsp.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
